// File: rtl/regfile_writer_if.sv
// regfile_writer_if: write-port arbiter bus (pipeline writeback, long-latency results, pending queries).
interface regfile_writer_if #(parameter int DEPTH = 4);
    logic                     a_valid;
    logic [4:0]               a_addr;
    logic [31:0]              a_data;
    logic                     b_valid;
    logic                     b_ready;
    logic [4:0]               b_addr;
    logic [31:0]              b_data;
    logic                     wen;
    logic [4:0]               write_addr;
    logic [31:0]              write_data;
    logic [4:0]               query_addr_0;
    logic [4:0]               query_addr_1;
    logic                     pending_0;
    logic                     pending_1;
    logic [$clog2(DEPTH):0]   fifo_count;
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, query_addr_0, query_addr_1,
        input  b_ready, wen, write_addr, write_data, pending_0, pending_1, fifo_count
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, query_addr_0, query_addr_1,
        output b_ready, wen, write_addr, write_data, pending_0, pending_1, fifo_count
    );
endinterface

// File: rtl/regfile_writer.sv
// regfile_writer: merges pipeline writeback (A) with FIFO-buffered long-latency results (B) onto one write port.
// Optional REGFILE_WRITER_CUTTHROUGH_EN lets B bypass an empty FIFO when the port is idle.
module regfile_writer #(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    regfile_writer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]    r_head, r_tail;
    logic [AW:0]      r_count;
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic             w_full, w_empty, w_push, w_pop, w_cut;
    logic [DEPTH-1:0] w_vld, w_hit0, w_hit1;
    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_empty = r_count == '0;
    assign bus.b_ready = !reset && !w_full;
`ifdef REGFILE_WRITER_CUTTHROUGH_EN
    assign w_cut = !reset && !bus.a_valid && w_empty && bus.b_valid && bus.b_addr != 5'd0;
`else
    assign w_cut = 1'b0;
`endif
    // Writes to r0 are dropped at the door so they never occupy a slot.
    assign w_push = bus.b_valid && bus.b_ready && bus.b_addr != 5'd0 && !w_cut;
    assign w_pop  = !reset && !bus.a_valid && !w_empty;
    assign bus.wen        = !reset && (bus.a_valid ? bus.a_addr != 5'd0 : (!w_empty || w_cut));
    assign bus.write_addr = reset ? 5'd0 : bus.a_valid ? bus.a_addr : !w_empty ? r_addr[r_head] :
                            w_cut ? bus.b_addr : 5'd0;
    assign bus.write_data = reset ? 32'd0 : bus.a_valid ? bus.a_data : !w_empty ? r_data[r_head] :
                            w_cut ? bus.b_data : 32'd0;
    assign bus.fifo_count = r_count;
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            // Slot i is live when its distance from head is below the occupancy.
            assign w_vld[i]  = {1'b0, AW'(i) - r_head} < r_count;
            assign w_hit0[i] = w_vld[i] && r_addr[i] == bus.query_addr_0;
            assign w_hit1[i] = w_vld[i] && r_addr[i] == bus.query_addr_1;
        end
    endgenerate
    assign bus.pending_0 = !reset && bus.query_addr_0 != 5'd0 && |w_hit0;
    assign bus.pending_1 = !reset && bus.query_addr_1 != 5'd0 && |w_hit1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop) r_head <= r_head + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.b_addr;
            r_data[r_tail] <= bus.b_data;
        end
    end
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: directed vector table, async-reset sequence and randomized run against a queue model.
module tb_regfile_writer;
    localparam int DEPTH = 4;
`ifdef REGFILE_WRITER_CUTTHROUGH_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif
    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [4:0]  q0, q1;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        br;
        logic [2:0]  cnt;
        logic        p0, p1;
    } vec_t;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int errs = 0;
    int checks = 0;
    ent_t q[$];
    vec_t tbl[16];

    regfile_writer_if #(.DEPTH(DEPTH)) bus ();
    regfile_writer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic vec_t mk(bit av, int aa, int ad, bit bv, int ba, int bd, int q0, int q1,
                                bit wen, int wa, int wd, bit br, int cnt, bit p0, bit p1);
        vec_t v;
        v.av = av; v.aa = 5'(aa); v.ad = 32'(ad); v.bv = bv; v.ba = 5'(ba); v.bd = 32'(bd);
        v.q0 = 5'(q0); v.q1 = 5'(q1); v.wen = wen; v.wa = 5'(wa); v.wd = 32'(wd);
        v.br = br; v.cnt = 3'(cnt); v.p0 = p0; v.p1 = p1;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(vec_t v);
        bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
        bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
        bus.query_addr_0 = v.q0; bus.query_addr_1 = v.q1;
    endtask

    task automatic compare(string tag, vec_t e);
        chk({tag, ".wen"}, 32'(bus.wen), 32'(e.wen));
        chk({tag, ".write_addr"}, 32'(bus.write_addr), 32'(e.wa));
        chk({tag, ".write_data"}, bus.write_data, e.wd);
        chk({tag, ".b_ready"}, 32'(bus.b_ready), 32'(e.br));
        chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(e.cnt));
        chk({tag, ".pending_0"}, 32'(bus.pending_0), 32'(e.p0));
        chk({tag, ".pending_1"}, 32'(bus.pending_1), 32'(e.p1));
    endtask

    function automatic bit in_q(logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic vec_t model_exp(vec_t v);
        vec_t e = v;
        bit cut = CT && !v.av && q.size() == 0 && v.bv && v.ba != 5'd0;
        e.br = q.size() < DEPTH;
        e.cnt = 3'(q.size());
        e.p0 = in_q(v.q0);
        e.p1 = in_q(v.q1);
        if (v.av) begin
            e.wen = v.aa != 5'd0; e.wa = v.aa; e.wd = v.ad;
        end else if (q.size() > 0) begin
            e.wen = 1'b1; e.wa = q[0].a; e.wd = q[0].d;
        end else if (cut) begin
            e.wen = 1'b1; e.wa = v.ba; e.wd = v.bd;
        end else begin
            e.wen = 1'b0; e.wa = 5'd0; e.wd = 32'd0;
        end
        return e;
    endfunction

    task automatic model_edge(vec_t v);
        bit ready = q.size() < DEPTH;
        bit cut = CT && !v.av && q.size() == 0 && v.bv && v.ba != 5'd0;
        if (!v.av && q.size() > 0) void'(q.pop_front());
        if (v.bv && ready && v.ba != 5'd0 && !cut) q.push_back('{a: v.ba, d: v.bd});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_cycle(string tag, vec_t v);
        set_in(v);
        #2;
        compare(tag, model_exp(v));
        model_edge(v);
        tick();
    endtask

    initial begin
        vec_t v;
        tbl[0] = mk(1, 5, 'h1234, 0, 0, 0, 5, 0, 1, 5, 'h1234, 1, 0, 0, 0);
        if (CT) begin
            tbl[1] = mk(0, 0, 0, 1, 8, 'hDEADBEEF, 8, 0, 1, 8, 'hDEADBEEF, 1, 0, 0, 0);
            tbl[2] = mk(0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0);
        end else begin
            tbl[1] = mk(0, 0, 0, 1, 8, 'hDEADBEEF, 8, 0, 0, 0, 0, 1, 0, 0, 0);
            tbl[2] = mk(0, 0, 0, 0, 0, 0, 8, 0, 1, 8, 'hDEADBEEF, 1, 1, 1, 0);
        end
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++)
            tbl[3+k] = mk(1, 20, 'hA0 + k, 1, k, 'h100 + k, k, k - 1, 1, 20, 'hA0 + k, 1, k - 1, 0, k > 1);
        tbl[8]  = mk(1, 20, 'hAA, 1, 9, 'h999, 4, 9, 1, 20, 'hAA, 0, 4, 1, 0);
        tbl[9]  = mk(0, 0, 0, 1, 9, 'h999, 1, 9, 1, 1, 'h101, 0, 4, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 10, 'hA10, 1, 2, 1, 2, 'h102, 1, 3, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 10, 3, 1, 3, 'h103, 1, 3, 1, 1);
        tbl[12] = mk(1, 0, 'h55, 1, 0, 'h66, 0, 4, 0, 0, 'h55, 1, 2, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 4, 10, 1, 4, 'h104, 1, 2, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 10, 0, 1, 10, 'hA10, 1, 1, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        set_in(mk(1, 7, 'h77, 1, 7, 'h77, 7, 7, 0, 0, 0, 0, 0, 0, 0));
        #3;
        compare("in_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #1;
        chk("release.b_ready", 32'(bus.b_ready), 32'd1);
        tick();

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i]);
            #2;
            compare($sformatf("tbl%0d", i), tbl[i]);
            model_edge(tbl[i]);
            tick();
        end

        for (int k = 11; k <= 13; k++)
            model_cycle("fill", mk(1, 20, 'h20, 1, k, 'h300 + k, k, 0, 0, 0, 0, 0, 0, 0, 0));
        set_in(mk(0, 0, 0, 0, 0, 0, 11, 13, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("prereset.wen", 32'(bus.wen), 32'd1);
        chk("prereset.count", 32'(bus.fifo_count), 32'd3);
        reset = 1'b1;
        #1;
        compare("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        q.delete();
        tick();
        reset = 1'b0;
        #1;
        chk("rerelease.b_ready", 32'(bus.b_ready), 32'd1);
        for (int i = 0; i < 3; i++)
            model_cycle("post_reset", mk(0, 0, 0, 0, 0, 0, 11, 12, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 400; i++) begin
            v = mk($urandom_range(0, 9) < 5, $urandom_range(0, 7), $urandom, $urandom_range(0, 9) < 7,
                   $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
                   0, 0, 0, 0, 0, 0, 0);
            model_cycle("rnd", v);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
